// File: rtl/note_history_buffer_pkg.sv
// Shared note types and history sizing for the note lookup / display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package note_pkg;
   localparam int NOTE_W     = 6;
   localparam int HIST_DEPTH = 160;
   localparam int REST_NOTE  = 0;

   typedef logic [NOTE_W-1:0] note_t;
endpackage

// File: rtl/note_history_buffer_if.sv
// Note stream in, history read port and debounced note status out.
// Latency: n/a (wiring only).
// Backpressure: none; samples are accepted every cycle they are valid.
interface note_history_buffer_if #(
   parameter int NOTE_W = note_pkg::NOTE_W,
   parameter int DEPTH  = note_pkg::HIST_DEPTH
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);

   logic [NOTE_W-1:0] note_in;
   logic              note_valid_in;
   logic              clear_in;
   logic [AW-1:0]     rd_offset_in;
   logic [NOTE_W-1:0] rd_data_out;
   logic [NOTE_W-1:0] note_out;
   logic              note_change_out;
   logic [FW-1:0]     fill_out;

   modport master (
      output note_in, note_valid_in, clear_in, rd_offset_in,
      input  rd_data_out, note_out, note_change_out, fill_out
   );

   modport slave (
      input  note_in, note_valid_in, clear_in, rd_offset_in,
      output rd_data_out, note_out, note_change_out, fill_out
   );
endinterface

// File: rtl/note_history_buffer_ring_ram.sv
// Simple dual-port history storage, one write and one read port, no reset.
// Latency: 1 cycle read, read-first on a same-address write.
// Backpressure: none.
module note_ring_ram
   import note_pkg::*;
#(
   parameter int DEPTH = HIST_DEPTH,
   parameter int W     = NOTE_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_in,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_dat,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_dat
);
   logic [W-1:0] mem [DEPTH];

   // Write and registered read share the edge; the read sees the old word.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
      rd_dat <= mem[rd_addr];
   end
endmodule

// File: rtl/note_history_buffer.sv
// Debounces per-frame note detections and keeps a circular history of committed notes.
// Latency: commit visible 1 cycle after the deciding sample; history read 1 cycle.
// Backpressure: none; every valid cycle is one sample, full history overwrites the oldest.
module note_history_buffer #(
   parameter int NOTE_W       = note_pkg::NOTE_W,
   parameter int DEPTH        = note_pkg::HIST_DEPTH,
   parameter int STABLE_COUNT = 4,
   parameter int REST_NOTE    = note_pkg::REST_NOTE,
   parameter bit RECORD_RESTS = 1'b0
) (
   input  logic clk_in,
   input  logic rst_in,
   note_history_buffer_if.slave bus
);
   localparam int                AW      = $clog2(DEPTH);
   localparam int                FW      = $clog2(DEPTH + 1);
   localparam logic [NOTE_W-1:0] REST    = NOTE_W'(REST_NOTE);
   localparam logic [3:0]        SAT     = 4'(STABLE_COUNT);
   localparam logic [AW-1:0]     LAST    = AW'(DEPTH - 1);
   localparam logic [FW-1:0]     FULL    = FW'(DEPTH);
   localparam logic [AW:0]       DEPTH_X = (AW + 1)'(DEPTH);
   localparam logic [AW:0]       ONE_X   = (AW + 1)'(1);

   logic [NOTE_W-1:0] cand;
   logic [3:0]        cnt;
   logic [NOTE_W-1:0] stable;
   logic [AW-1:0]     wr_ptr;
   logic [FW-1:0]     fill;
   logic              chg_q;
   logic              rd_hit_q;

   logic [3:0]        cnt_nxt;
   logic              commit;
   logic              hist_wr;
   logic [AW:0]       off_x;
   logic [AW:0]       ptr_x;
   logic [AW-1:0]     rd_addr;
   logic              rd_hit;
   logic [NOTE_W-1:0] ram_dat;

   // Match counting and commit decision for the sample on the bus this cycle.
   always_comb begin
      cnt_nxt = 4'd1;
      if (bus.note_in == cand) begin
         cnt_nxt = (cnt >= SAT) ? SAT : cnt + 4'd1;
      end
      commit  = bus.note_valid_in && (cnt_nxt == SAT) && (bus.note_in != stable);
      hist_wr = rst_in && commit && !bus.clear_in
                && (RECORD_RESTS || (bus.note_in != REST));
   end

   // Age-to-address mapping without assuming a power-of-two depth.
   always_comb begin
      off_x = {1'b0, bus.rd_offset_in};
      if (off_x >= DEPTH_X) begin
         off_x = '0;  // out-of-range ages are masked by rd_hit anyway
      end
      ptr_x = {1'b0, wr_ptr};
      if (ptr_x > off_x) begin
         rd_addr = AW'(ptr_x - off_x - ONE_X);
      end else begin
         rd_addr = AW'(ptr_x + DEPTH_X - off_x - ONE_X);
      end
      rd_hit = FW'(bus.rd_offset_in) < fill;
   end

   // Debounce, pointer and fill state; clear outranks a same-cycle commit.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cand     <= REST;
         cnt      <= 4'd0;
         stable   <= REST;
         wr_ptr   <= '0;
         fill     <= '0;
         chg_q    <= 1'b0;
         rd_hit_q <= 1'b0;
      end else begin
         chg_q    <= 1'b0;
         rd_hit_q <= rd_hit;
         if (bus.note_valid_in) begin
            cand <= bus.note_in;
            cnt  <= cnt_nxt;
         end
         if (bus.clear_in) begin
            wr_ptr <= '0;
            fill   <= '0;
            stable <= REST;
         end else if (commit) begin
            stable <= bus.note_in;
            chg_q  <= 1'b1;
            if (hist_wr) begin
               wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
               if (fill != FULL) begin
                  fill <= fill + FW'(1);
               end
            end
         end
      end
   end

   note_ring_ram #(
      .DEPTH (DEPTH),
      .W     (NOTE_W),
      .AW    (AW)
   ) u_ram (
      .clk_in  (clk_in),
      .wr_en   (hist_wr),
      .wr_addr (wr_ptr),
      .wr_dat  (bus.note_in),
      .rd_addr (rd_addr),
      .rd_dat  (ram_dat)
   );

   // Stale or never-written entries read back as a rest.
   assign bus.rd_data_out     = rd_hit_q ? ram_dat : REST;
   assign bus.note_out        = stable;
   assign bus.note_change_out = chg_q;
   assign bus.fill_out        = fill;
endmodule
